// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NAND = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_XNOR = 4'd11;
    localparam logic [3:0] OP_SHL  = 4'd12;
    localparam logic [3:0] OP_SHR  = 4'd13;
    localparam logic [3:0] OP_ROR  = 4'd14;
    localparam logic [3:0] OP_ROL  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLG_CARRY = 0;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_ERR   = 3;
    localparam int FLG_N     = 4;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) / restoring divider, one bit per cycle.
// o_result is the value after the current step, so it is the final answer in the o_done cycle.
module alu_iter_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             r_busy;
    logic             r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;   // MUL: partial product high; DIV: partial remainder
    logic [WIDTH-1:0] r_lo;   // MUL: multiplier/product low; DIV: dividend/quotient
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    // One iteration step of either algorithm
    always_comb begin
        w_sum   = '0;
        w_trial = '0;
        w_hi    = r_hi;
        w_lo    = r_lo;
        if (r_div) begin
            // Remainder stays below divisor, so the trial difference sign is bit WIDTH
            w_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
            if (!w_trial[WIDTH]) begin
                w_hi = w_trial[WIDTH-1:0];
                w_lo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
                w_lo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
            {w_hi, w_lo} = {w_sum, r_lo[WIDTH-1:1]};
        end
    end

    // Operand load on start, then WIDTH steps while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_div  <= i_div;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= i_a;
            r_b    <= i_b;
        end else if (r_busy) begin
            r_hi  <= w_hi;
            r_lo  <= w_lo;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) r_busy <= 1'b0;
        end
    end

    assign o_done   = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_result = {w_hi, w_lo};

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle logic/add/shift ops, iterative MUL/DIV via alu_iter_muldiv.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         s,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               carry,
    output logic               zero,
    output logic               ovf,
    output logic               err
);
    localparam int LG  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_t             r_state, w_next;
    logic [3:0]         r_op;
    logic [2*WIDTH-1:0] r_y;
    logic [FLG_N-1:0]   r_flags;

    logic               w_acc, w_start, w_md_done, w_md_load, w_load;
    logic [2*WIDTH-1:0] w_md_res, w_y, w_ld_y, w_rot;
    logic [WIDTH:0]     w_ext;
    logic [LG-1:0]      w_sh;
    logic               w_c, w_o, w_e;
    logic [FLG_N-1:0]   w_ld_flags;

    // Ready is forced low while reset is asserted
    assign in_ready  = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign out_valid = (r_state == ST_DONE);
    assign w_acc     = in_valid && in_ready;
    // DIV by zero resolves in one cycle without touching the iterative unit
    assign w_start   = w_acc && ((s == OP_MUL) || ((s == OP_DIV) && (b != '0)));
    assign w_md_load = (r_state == ST_BUSY) && w_md_done;
    assign w_load    = w_md_load || (w_acc && !w_start);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_div    (s == OP_DIV),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_md_done),
        .o_result (w_md_res)
    );

    // Single-cycle datapath on the request operands
    always_comb begin
        w_y   = '0;
        w_c   = 1'b0;
        w_o   = 1'b0;
        w_e   = 1'b0;
        w_ext = '0;
        w_rot = '0;
        w_sh  = b[LG-1:0];
        case (s)
            OP_ADD: begin
                w_ext = {1'b0, a} + {1'b0, b};
                w_c   = w_ext[WIDTH];
                w_o   = (a[MSB] == b[MSB]) && (w_ext[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_ext = {1'b0, a} - {1'b0, b};
                w_c   = w_ext[WIDTH];
                w_o   = (a[MSB] != b[MSB]) && (w_ext[MSB] != a[MSB]);
            end
            OP_INC: begin
                w_ext = {1'b0, a} + 1'b1;
                w_c   = w_ext[WIDTH];
                w_o   = !a[MSB] && w_ext[MSB];
            end
            OP_DEC: begin
                w_ext = {1'b0, a} - 1'b1;
                w_c   = w_ext[WIDTH];
                w_o   = a[MSB] && !w_ext[MSB];
            end
            OP_DIV: begin
                w_y = {a, {WIDTH{1'b1}}};
                w_e = 1'b1;
            end
            OP_AND:  w_y[MSB:0] = a & b;
            OP_OR:   w_y[MSB:0] = a | b;
            OP_XOR:  w_y[MSB:0] = a ^ b;
            OP_NAND: w_y[MSB:0] = ~(a & b);
            OP_NOR:  w_y[MSB:0] = ~(a | b);
            OP_XNOR: w_y[MSB:0] = ~(a ^ b);
            OP_SHL: begin
                w_ext = {1'b0, a} << w_sh;
                w_c   = w_ext[WIDTH];
            end
            OP_SHR: begin
                w_ext      = {a, 1'b0} >> w_sh;
                w_y[MSB:0] = w_ext[WIDTH:1];
                w_c        = w_ext[0];
            end
            OP_ROR: begin
                w_rot      = {a, a} >> w_sh;
                w_y[MSB:0] = w_rot[MSB:0];
            end
            OP_ROL: begin
                w_rot      = {a, a} << w_sh;
                w_y[MSB:0] = w_rot[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
        if ((s == OP_ADD) || (s == OP_SUB) || (s == OP_INC) || (s == OP_DEC) || (s == OP_SHL))
            w_y[MSB:0] = w_ext[MSB:0];
    end

    // Select the result being captured: iterative unit or single-cycle path
    always_comb begin
        w_ld_flags = '0;
        if (w_md_load) begin
            w_ld_y              = w_md_res;
            w_ld_flags[FLG_OVF] = (r_op == OP_MUL) && (|w_md_res[2*WIDTH-1:WIDTH]);
        end else begin
            w_ld_y                = w_y;
            w_ld_flags[FLG_CARRY] = w_c;
            w_ld_flags[FLG_OVF]   = w_o;
            w_ld_flags[FLG_ERR]   = w_e;
        end
        w_ld_flags[FLG_ZERO] = (w_ld_y == '0);
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_acc) w_next = w_start ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_md_done) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = w_acc ? (w_start ? ST_BUSY : ST_DONE) : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State, latched opcode and held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_ADD;
            r_y     <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc) r_op <= s;
            if (w_load) begin
                r_y     <= w_ld_y;
                r_flags <= w_ld_flags;
            end
        end
    end

    assign y     = r_y;
    assign carry = r_flags[FLG_CARRY];
    assign zero  = r_flags[FLG_ZERO];
    assign ovf   = r_flags[FLG_OVF];
    assign err   = r_flags[FLG_ERR];

endmodule

// File: tb/tb_alu_iter.sv
// Randomized and directed bench for alu_iter (WIDTH=8) against an arithmetic reference model.
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0, b = '0;
    logic [3:0]  s = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] y;
    logic        carry, zero, ovf, err;

    int checks = 0;
    int errors = 0;

    logic [15:0] got_y;
    logic        got_c, got_z, got_o, got_e, busy_bad;
    int          got_lat;

    alu_iter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .carry(carry), .zero(zero), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: results computed from the opcode definitions with integer arithmetic
    function automatic void model(input logic [3:0] op, input logic [7:0] x, v,
                                  output logic [15:0] ey, output logic ec, eo, ee);
        int ux, uv, sx, sv, sh, r;
        ux = int'(x); uv = int'(v);
        sx = int'($signed(x)); sv = int'($signed(v));
        sh = int'(v[2:0]);
        r = 0; ec = 1'b0; eo = 1'b0; ee = 1'b0;
        case (op)
            4'd0:  begin r = ux + uv; ec = (r > 255); eo = (sx + sv > 127) || (sx + sv < -128); end
            4'd1:  begin r = ux - uv; ec = (ux < uv); eo = (sx - sv > 127) || (sx - sv < -128); end
            4'd2:  begin r = ux + 1; ec = (ux == 255); eo = (sx + 1 > 127); end
            4'd3:  begin r = ux - 1; ec = (ux == 0); eo = (sx - 1 < -128); end
            4'd4:  begin r = ux * uv; eo = (r > 255); end
            4'd5:  if (uv == 0) begin r = ux * 256 + 255; ee = 1'b1; end
                   else r = (ux % uv) * 256 + ux / uv;
            4'd6:  r = ux & uv;
            4'd7:  r = ux | uv;
            4'd8:  r = ux ^ uv;
            4'd9:  r = 255 - (ux & uv);
            4'd10: r = 255 - (ux | uv);
            4'd11: r = 255 - (ux ^ uv);
            4'd12: begin r = ux << sh; ec = (((r >> 8) & 1) == 1); end
            4'd13: begin r = ux >> sh; if (sh != 0) ec = (((ux >> (sh - 1)) & 1) == 1); end
            4'd14: r = (ux >> sh) | (ux << (8 - sh));
            default: r = (ux << sh) | (ux >> (8 - sh));
        endcase
        if (op == 4'd4 || op == 4'd5) ey = 16'(r);
        else ey = 16'(r & 255);
    endfunction

    // Issue one request, wait for its result; captures outputs and latency
    task automatic run_op(input logic [3:0] op, input logic [7:0] x, v);
        int n;
        @(negedge clk);
        s = op; a = x; b = v; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL accept_timeout in_ready=%b required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); s = 4'($urandom);
        got_lat = 1; busy_bad = 1'b0;
        while (!out_valid && got_lat < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1; got_lat++;
        end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL result_timeout op=%0d out_valid=%b required 1", op, out_valid); end
        got_y = y; got_c = carry; got_z = zero; got_o = ovf; got_e = err;
    endtask

    task automatic release_out();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (y !== 16'h0) begin errors++; $display("FAIL rst_y got %h exp 0000", y); end
        checks++; if ({carry, zero, ovf, err} !== 4'b0) begin
            errors++; $display("FAIL rst_flags got %b exp 0000", {carry, zero, ovf, err}); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [3:0]  t_op [10] = '{4'd0, 4'd0, 4'd4, 4'd5, 4'd5, 4'd12, 4'd15, 4'd13, 4'd2, 4'd3};
        logic [7:0]  t_a  [10] = '{8'hFF, 8'h7F, 8'hFF, 8'd200, 8'd5, 8'h81, 8'h81, 8'h81, 8'hFF, 8'h00};
        logic [7:0]  t_b  [10] = '{8'h01, 8'h01, 8'hFF, 8'd7, 8'd0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
        logic [15:0] t_y  [10] = '{16'h0000, 16'h0080, 16'hFE01, 16'h041C, 16'h05FF,
                                   16'h0002, 16'h0003, 16'h0081, 16'h0000, 16'h00FF};
        logic [2:0]  t_f  [10] = '{3'b100, 3'b010, 3'b010, 3'b000, 3'b001,
                                   3'b100, 3'b000, 3'b000, 3'b100, 3'b100};  // {carry,ovf,err}
        int          t_l  [10] = '{1, 1, 9, 9, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            run_op(t_op[i], t_a[i], t_b[i]);
            checks++; if (got_y !== t_y[i]) begin
                errors++; $display("FAIL dir%0d_y got %h exp %h", i, got_y, t_y[i]); end
            checks++; if ({got_c, got_o, got_e} !== t_f[i]) begin
                errors++; $display("FAIL dir%0d_flags got %b exp %b", i, {got_c, got_o, got_e}, t_f[i]); end
            checks++; if (got_z !== (t_y[i] == 16'h0)) begin
                errors++; $display("FAIL dir%0d_zero got %b exp %b", i, got_z, t_y[i] == 16'h0); end
            checks++; if (got_lat != t_l[i]) begin
                errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, got_lat, t_l[i]); end
            checks++; if (busy_bad !== 1'b0) begin
                errors++; $display("FAIL dir%0d_busy_ready got %b exp 0", i, busy_bad); end
            release_out();
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [7:0]  x, v;
        logic [15:0] ey;
        logic        ec, eo, ee;
        int          el;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = 8'($urandom);
            v  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            model(op, x, v, ey, ec, eo, ee);
            el = (op == 4'd4 || (op == 4'd5 && v != 8'h00)) ? 9 : 1;
            run_op(op, x, v);
            checks++; if ({got_y, got_c, got_z, got_o, got_e} !== {ey, ec, ey == 16'h0, eo, ee}) begin
                errors++;
                $display("FAIL rnd op=%0d a=%h b=%h got y=%h c%b z%b o%b e%b exp y=%h c%b z%b o%b e%b",
                         op, x, v, got_y, got_c, got_z, got_o, got_e, ey, ec, ey == 16'h0, eo, ee);
            end
            checks++; if (got_lat != el) begin
                errors++; $display("FAIL rnd_latency op=%0d got %0d exp %0d", op, got_lat, el); end
            release_out();
            checks++; if (out_valid !== 1'b0) begin
                errors++; $display("FAIL rnd_drain out_valid got %b exp 0", out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        run_op(4'd0, 8'h12, 8'h34);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if ({out_valid, y, carry, zero, ovf, err} !== {1'b1, 16'h0046, 4'b0000}) begin
                errors++; $display("FAIL hold%0d got v%b y=%h f=%b exp v1 y=0046 f=0000",
                                   i, out_valid, y, {carry, zero, ovf, err});
            end
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; s = 4'd1; a = 8'h00; b = 8'h01;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if ({out_valid, y, carry, zero, ovf, err} !== {1'b1, 16'h00FF, 4'b1000}) begin
            errors++; $display("FAIL b2b_result got v%b y=%h f=%b exp v1 y=00FF f=1000",
                               out_valid, y, {carry, zero, ovf, err});
        end
        release_out();
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        s = 4'd4; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        checks++; if ({out_valid, in_ready} !== 2'b00) begin
            errors++; $display("FAIL midrst_handshake got v%b r%b exp v0 r0", out_valid, in_ready); end
        checks++; if (y !== 16'h0) begin errors++; $display("FAIL midrst_y got %h exp 0000", y); end
        checks++; if ({carry, zero, ovf, err} !== 4'b0) begin
            errors++; $display("FAIL midrst_flags got %b exp 0000", {carry, zero, ovf, err}); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release got %b exp 1", in_ready); end
        run_op(4'd0, 8'd3, 8'd4);
        checks++; if (got_y !== 16'h0007 || got_lat != 1) begin
            errors++; $display("FAIL post_rst_add got y=%h lat %0d exp y=0007 lat 1", got_y, got_lat); end
        release_out();
        run_op(4'd4, 8'd3, 8'd5);
        checks++; if (got_y !== 16'h000F || got_lat != 9) begin
            errors++; $display("FAIL post_rst_mul got y=%h lat %0d exp y=000F lat 9", got_y, got_lat); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
